// File: rtl/instruction_fetch.sv
// Fetch stage: owns the word-addressed PC, reads instruction memory combinationally and
// registers {pc, instruction} into an IF/ID slot handed to decode via valid/ready.
module instruction_fetch #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_address,
  input  logic [DATA_W-1:0] instruction_set,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              slot_free;

  assign accept    = vld_p1 & id_ready;
  assign slot_free = ~vld_p1 | id_ready;

  // p0: PC drives memory; p1: IF/ID register toward decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BOOT;
      pc_p0    <= PC_RESET;
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      cnt      <= '0;
    end else if (branch_taken) begin
      // Redirect flushes the slot regardless of decode readiness
      pc_p0  <= branch_target;
      vld_p1 <= 1'b0;
      state  <= (branch_target >= PC_LIMIT) ? ST_HALT : ST_FETCH;
    end else begin
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (slot_free) begin
            instr_p1 <= instruction_set;
            pc_p1    <= pc_p0;
            vld_p1   <= 1'b1;
            cnt      <= sat_inc(cnt);
            if (pc_p0 == PC_LAST) state <= ST_HALT;
            else                  pc_p0 <= pc_p0 + ADDR_W'(1);
          end
        end
        ST_HALT: if (accept) vld_p1 <= 1'b0;
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign pc_address  = pc_p0;
  assign if_valid    = vld_p1;
  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign halted      = (state == ST_HALT);
  assign fetch_count = cnt;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic checked every cycle
// against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] pc_address;
  logic [DATA_W-1:0] instruction_set;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              id_ready = 1'b0;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;
  logic [CNT_W-1:0]  fetch_count;

  int checks = 0;
  int errors = 0;

  // Model state: where the PC points, what sits in the decode slot, and the mode
  logic [31:0] m_pc;
  bit          m_boot, m_halt, m_v;
  logic [31:0] m_instr, m_ipc;
  int          m_cnt;

  instruction_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc_address(pc_address), .instruction_set(instruction_set),
    .branch_taken(branch_taken), .branch_target(branch_target), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < DEPTH) ? 32'h100 + a : (32'hDEAD_0000 ^ a);
  endfunction

  assign instruction_set = mem_word(pc_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_boot = 1; m_halt = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
  endtask

  // One rising edge worth of the fetch rules
  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (branch_taken) begin
      m_pc = branch_target; m_v = 0; m_boot = 0;
      m_halt = (branch_target >= DEPTH);
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (m_v && id_ready) m_v = 0;
    end else if (!m_v || id_ready) begin
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_v = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_pc == DEPTH - 1) m_halt = 1;
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic compare_all();
    chk("pc_address", 64'(pc_address), 64'(m_pc));
    chk("if_valid", 64'(if_valid), 64'(m_v));
    if (m_v) begin
      chk("if_instr", 64'(if_instr), 64'(m_instr));
      chk("if_pc", 64'(if_pc), 64'(m_ipc));
    end
    chk("halted", 64'(halted), 64'(m_halt));
    chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_pc_address", 64'(pc_address), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fetch_count", 64'(fetch_count), 64'd0);

    // Release between edges; first edge is the boot bubble
    #9 rst = 1'b1; id_ready = 1'b1;
    step();
    chk("boot_no_valid", 64'(if_valid), 64'd0);
    step();
    chk("first_if_pc", 64'(if_pc), 64'd0);
    chk("first_if_instr", 64'(if_instr), 64'h100);
    chk("first_valid", 64'(if_valid), 64'd1);
    for (int i = 0; i < 5; i++) step();
    chk("pre_stall_if_pc", 64'(if_pc), 64'd5);

    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_if_pc", 64'(if_pc), 64'd5);
      chk("stall_if_instr", 64'(if_instr), 64'h105);
      chk("stall_pc_address", 64'(pc_address), 64'd6);
    end
    id_ready = 1'b1;
    step();
    chk("resume_if_pc", 64'(if_pc), 64'd6);
    chk("resume_count", 64'(fetch_count), 64'd7);

    // Branch while the slot is full and decode stalled
    id_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'd20;
    step();
    chk("br_flush_valid", 64'(if_valid), 64'd0);
    chk("br_pc_address", 64'(pc_address), 64'd20);
    branch_taken = 1'b0; id_ready = 1'b1;
    step();
    chk("br_if_pc", 64'(if_pc), 64'd20);
    chk("br_if_instr", 64'(if_instr), 64'h114);
    chk("br_valid", 64'(if_valid), 64'd1);
    step();

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_pc_address", 64'(pc_address), 64'd0);
    chk("async_if_valid", 64'(if_valid), 64'd0);
    chk("async_if_pc", 64'(if_pc), 64'd0);
    chk("async_if_instr", 64'(if_instr), 64'd0);
    chk("async_fetch_count", 64'(fetch_count), 64'd0);
    #2 rst = 1'b1;
    step();
    chk("async_boot_bubble", 64'(if_valid), 64'd0);

    // Run to end of memory
    for (int i = 0; i < 40 && !(if_valid && if_pc == 31); i++) step();
    chk("end_if_pc", 64'(if_pc), 64'd31);
    chk("end_halted", 64'(halted), 64'd1);
    chk("end_pc_address", 64'(pc_address), 64'd31);
    chk("end_fetch_count", 64'(fetch_count), 64'd32);
    step();
    chk("halt_valid_drop", 64'(if_valid), 64'd0);
    id_ready = 1'b0;
    step();
    chk("halt_pc_hold", 64'(pc_address), 64'd31);
    chk("halt_stays", 64'(halted), 64'd1);

    branch_taken = 1'b1; branch_target = 32'd3; id_ready = 1'b1;
    step();
    chk("unhalt", 64'(halted), 64'd0);
    branch_taken = 1'b0;
    step();
    chk("unhalt_if_pc", 64'(if_pc), 64'd3);
    chk("unhalt_valid", 64'(if_valid), 64'd1);

    // Branch beyond memory
    branch_taken = 1'b1; branch_target = 32'd40;
    step();
    chk("oob_halted", 64'(halted), 64'd1);
    chk("oob_valid", 64'(if_valid), 64'd0);
    chk("oob_count", 64'(fetch_count), 64'd33);
    chk("oob_pc_address", 64'(pc_address), 64'd40);
    branch_taken = 1'b0;
    step();
    chk("oob_hold_count", 64'(fetch_count), 64'd33);

    // Random traffic, long enough to reach counter saturation
    for (int i = 0; i < 600; i++) begin
      id_ready      = ($urandom_range(0, 9) < 7);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = 32'($urandom_range(0, 39));
      step();
    end
    chk("saturated_count", 64'(fetch_count), 64'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
